// File: rtl/frame_scan_if.sv
// Bundle for frame_scan_ctrl: start/status, frame-buffer read port and pixel stream.
// master = controller side, slave = environment (memory + downstream chain).
interface frame_scan_if #(
    parameter int ADDR_W = 19,
    parameter int CW     = 10,
    parameter int RW     = 9
);
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic [7:0]        pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [CW-1:0]     pix_col;
    logic [RW-1:0]     pix_row;
    logic              pix_sof;
    logic              pix_eof;
    logic              pix_sol;
    logic              pix_eol;

    modport master (
        input  start, mem_data, pix_ready,
        output busy, done, mem_rd_en, mem_addr,
        output pix_data, pix_valid, pix_col, pix_row,
        output pix_sof, pix_eof, pix_sol, pix_eol
    );

    modport slave (
        output start, mem_data, pix_ready,
        input  busy, done, mem_rd_en, mem_addr,
        input  pix_data, pix_valid, pix_col, pix_row,
        input  pix_sof, pix_eof, pix_sol, pix_eol
    );
endinterface

// File: rtl/frame_scan_ctrl.sv
// Raster-scan read controller: walks a COLxROW frame buffer in raster order and
// streams the returned pixels with coordinates and frame/line markers.
module frame_scan_ctrl #(
    parameter int COL    = 640,
    parameter int ROW    = 480,
    parameter int ADDR_W = 19,
    parameter int CW     = 10,
    parameter int RW     = 9
) (
    input  logic          clk,
    input  logic          rst,
    frame_scan_if.master  bus
);
    localparam int              N      = COL * ROW;
    localparam logic [ADDR_W:0] L_N    = (ADDR_W+1)'(N);
    localparam logic [ADDR_W-1:0] L_LAST = ADDR_W'(N - 1);
    localparam logic [CW-1:0]   L_CMAX = CW'(COL - 1);
    localparam logic [RW-1:0]   L_RMAX = RW'(ROW - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_inflight;
    logic [1:0][7:0]   r_fifo;
    logic              r_wp, r_rp;
    logic [1:0]        r_cnt;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;

    logic              w_valid, w_pop, w_fifo_pop, w_wr, w_rd_en, w_begin;
    logic [2:0]        w_level;
    logic [7:0]        w_head;

    // An empty buffer with a read returning this cycle exposes mem_data directly,
    // which gives the 2-cycle start-to-pixel latency.
    assign w_valid    = (r_cnt != 2'd0) || r_inflight;
    assign w_head     = (r_cnt != 2'd0) ? r_fifo[r_rp] : (r_inflight ? bus.mem_data : 8'd0);
    assign w_pop      = w_valid && bus.pix_ready;
    assign w_fifo_pop = w_pop && (r_cnt != 2'd0);
    assign w_wr       = r_inflight && !((r_cnt == 2'd0) && w_pop);
    assign w_level    = {1'b0, r_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_rd_en    = (r_state == S_RUN) && (w_level < 3'd2) && ({1'b0, r_addr} < L_N);
    assign w_begin    = (r_state == S_IDLE) && bus.start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
            S_RUN:   if (w_rd_en && (r_addr == L_LAST)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_level == 3'd0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_inflight <= 1'b0;
            r_fifo     <= '0;
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_cnt      <= 2'd0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_begin)      r_addr <= '0;
            else if (w_rd_en) r_addr <= r_addr + 1'b1;
            if (w_wr) begin
                r_fifo[r_wp] <= bus.mem_data;
                r_wp         <= ~r_wp;
            end
            if (w_fifo_pop) r_rp <= ~r_rp;
            r_cnt <= r_cnt + {1'b0, w_wr} - {1'b0, w_fifo_pop};
        end
    end

    // Coordinates track the head pixel, not the issue address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_begin) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_pop) begin
            if (r_col == L_CMAX) begin
                r_col <= '0;
                r_row <= (r_row == L_RMAX) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign bus.busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign bus.done      = (r_state == S_DONE);
    assign bus.mem_rd_en = w_rd_en;
    assign bus.mem_addr  = r_addr;
    assign bus.pix_valid = w_valid;
    assign bus.pix_data  = w_head;
    assign bus.pix_col   = r_col;
    assign bus.pix_row   = r_row;
    assign bus.pix_sof   = w_valid && (r_col == '0) && (r_row == '0);
    assign bus.pix_eof   = w_valid && (r_col == L_CMAX) && (r_row == L_RMAX);
    assign bus.pix_sol   = w_valid && (r_col == '0);
    assign bus.pix_eol   = w_valid && (r_col == L_CMAX);
endmodule

// File: tb/tb_frame_scan_ctrl.sv
// Scoreboard bench for frame_scan_ctrl on a 4x3 frame: reads push expected pixels,
// stream transfers pop and compare; directed checks cover timing, stalls and reset.
module tb_frame_scan_ctrl;
    localparam int COL = 4, ROW = 3, ADDR_W = 4, CW = 2, RW = 2;
    localparam int N = COL * ROW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_scan_if #(.ADDR_W(ADDR_W), .CW(CW), .RW(RW)) bus ();

    frame_scan_ctrl #(.COL(COL), .ROW(ROW), .ADDR_W(ADDR_W), .CW(CW), .RW(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Synchronous-read frame buffer: word k = k; junk when not read.
    always @(posedge clk) bus.mem_data <= bus.mem_rd_en ? 8'(bus.mem_addr) : 8'hEE;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    int t0 = 0, exp_addr = 0, outst = 0, pop_cnt = 0, rd_cnt = 0;
    int first_pix_rel = -1, done_rel = -1, done_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_head  = '0;
    logic [31:0] q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_pix(input int k);
        int c, r;
        c = k % COL;
        r = k / COL;
        return {16'd0, 8'(k), 2'(c), 2'(r), (k == 0), (k == N-1), (c == 0), (c == COL-1)};
    endfunction

    function automatic logic [31:0] head();
        return {16'd0, bus.pix_data, bus.pix_col, bus.pix_row,
                bus.pix_sof, bus.pix_eof, bus.pix_sol, bus.pix_eol};
    endfunction

    function automatic logic [31:0] outs();
        return {8'd0, bus.busy, bus.done, bus.mem_rd_en, bus.mem_addr, bus.pix_valid,
                bus.pix_data, bus.pix_col, bus.pix_row,
                bus.pix_sof, bus.pix_eof, bus.pix_sol, bus.pix_eol};
    endfunction

    // Monitor samples on the falling edge, mid-cycle.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            logic pop, rd;
            logic [31:0] h;
            pop = bus.pix_valid && bus.pix_ready;
            rd  = bus.mem_rd_en;
            h   = head();
            if (prev_stall) begin
                chk("hold_valid", bus.pix_valid, 1'b1);
                chk("hold_head", h, prev_head);
            end
            if (rd) begin
                chk("rd_addr", bus.mem_addr, exp_addr);
                chk("rd_range", exp_addr < N, 1'b1);
                chk("credit", (outst - int'(pop) + 1) <= 2, 1'b1);
                q.push_back(exp_pix(exp_addr));
                exp_addr++;
                rd_cnt++;
            end
            if (pop) begin
                if (q.size() == 0) chk("underrun", 1'b1, 1'b0);
                else               chk("pix", h, q.pop_front());
                if (first_pix_rel < 0) first_pix_rel = cyc - t0;
                pop_cnt++;
            end else if (!bus.pix_valid) begin
                chk("marks_off", {bus.pix_sof, bus.pix_eof, bus.pix_sol, bus.pix_eol}, 4'd0);
            end
            outst = outst + int'(rd) - int'(pop);
            if (bus.done) begin
                done_cnt++;
                done_rel = cyc - t0;
            end
            prev_stall = bus.pix_valid && !bus.pix_ready;
            prev_head  = h;
        end
    end

    // All stimulus moves at posedge+1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; that cycle becomes cycle 0 of the frame.
    task automatic start_frame();
        bus.start     = 1'b1;
        t0            = cyc;
        exp_addr      = 0;
        pop_cnt       = 0;
        rd_cnt        = 0;
        first_pix_rel = -1;
        done_rel      = -1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input logic rand_ready);
        int n, d0;
        n  = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            if (rand_ready) bus.pix_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("done_timeout", done_cnt != d0, 1'b1);
        bus.pix_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dsave;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.pix_ready = 1'b0;
        repeat (2) tick();
        chk("rst_outs", outs(), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_outs", outs(), 32'd0);

        // Plain frame, ready held high.
        bus.pix_ready = 1'b1;
        start_frame();
        chk("c1_read", {bus.busy, bus.mem_rd_en, bus.mem_addr}, {1'b1, 1'b1, 4'd0});
        tick();
        chk("c2_head", {bus.pix_valid, bus.pix_data, bus.pix_sof}, {1'b1, 8'd0, 1'b1});
        wait_done(40, 1'b0);
        chk("first_pix", first_pix_rel, 2);
        chk("done_cyc", done_rel, 14);
        chk("npix", pop_cnt, N);
        chk("idle_after", {bus.busy, bus.done}, 2'b00);

        // start while busy and during DONE ignored; start in first IDLE accepted.
        tick();
        start_frame();
        repeat (4) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        while ((cyc - t0) < 14) tick();
        chk("done_pulse", {bus.done, bus.busy}, 2'b10);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("done_start_ign", {bus.busy, bus.mem_rd_en}, 2'b00);
        chk("npix_b", pop_cnt, N);
        start_frame();
        chk("b2b_read", {bus.mem_rd_en, bus.mem_addr, bus.pix_col, bus.pix_row},
            {1'b1, 4'd0, 2'd0, 2'd0});
        wait_done(40, 1'b0);
        chk("b2b_done", done_rel, 14);
        chk("npix_c", pop_cnt, N);

        // Random backpressure.
        for (int f = 0; f < 3; f++) begin
            tick();
            bus.pix_ready = 1'($urandom_range(0, 1));
            start_frame();
            wait_done(300, 1'b1);
            chk("npix_rand", pop_cnt, N);
            chk("rd_rand", rd_cnt, N);
        end

        // Full stall from cycle 0, release at cycle 10.
        tick();
        bus.pix_ready = 1'b0;
        start_frame();
        while ((cyc - t0) < 10) tick();
        chk("stall_reads", rd_cnt, 2);
        chk("stall_rd_off", bus.mem_rd_en, 1'b0);
        bus.pix_ready = 1'b1;
        #1;
        chk("resume", {bus.mem_rd_en, bus.mem_addr}, {1'b1, 4'd2});
        wait_done(40, 1'b0);
        chk("stall_done", done_rel, 22);
        chk("npix_stall", pop_cnt, N);

        // Asynchronous reset mid-frame after pixel 5.
        tick();
        start_frame();
        n = 0;
        while (pop_cnt < 6 && n < 50) begin
            tick();
            n++;
        end
        chk("reach_pix5", pop_cnt >= 6, 1'b1);
        dsave = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_outs", outs(), 32'd0);
        tick();
        tick();
        chk("rst_hold_outs", outs(), 32'd0);
        q.delete();
        outst      = 0;
        prev_stall = 1'b0;
        rst        = 1'b0;
        tick();
        chk("no_done_rst", done_cnt, dsave);
        chk("post_rst_outs", outs(), 32'd0);
        start_frame();
        tick();
        chk("rst_restart", {bus.pix_valid, bus.pix_data, bus.pix_sof}, {1'b1, 8'd0, 1'b1});
        wait_done(40, 1'b0);
        chk("rst_done", done_rel, 14);
        chk("npix_rst", pop_cnt, N);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
